maze_port_arbiter: RTL and testbench

// - Shares the single maze memory port (row/col/maze_oe/maze_we/maze_in) between N_REQ maze-solver requesters.
// - Each requester issues cell reads (test for wall/path) or cell marks (write path bit).
// - Fair round-robin arbitration; one access in flight at a time.
// - Sits between the solver instances and the maze memory model/RAM.

---
 rtl/maze_port_arbiter.sv | 102 ++++++++++
 tb/tb_maze_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_port_arbiter.sv
// rtl/maze_port_arbiter.sv - round-robin arbiter sharing one maze memory port among N_REQ solvers
module maze_port_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_row,
    input  logic [N_REQ*ADDR_W-1:0]   req_col,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rd_valid,
    output logic                      rd_data,
    output logic                      busy,
    output logic [ADDR_W-1:0]         row,
    output logic [ADDR_W-1:0]         col,
    output logic                      maze_oe,
    output logic                      maze_we,
    input  logic                      maze_in
);
    localparam int PTR_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cur;
    logic [PTR_W-1:0] win;
    logic [PTR_W-1:0] cand;
    logic             found;

    // Scan starts just after the last winner so the previous grantee has lowest priority.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= PTR_W'(N_REQ - 1);
            cur      <= '0;
            gnt      <= '0;
            rd_valid <= '0;
            rd_data  <= 1'b0;
            busy     <= 1'b0;
            row      <= '0;
            col      <= '0;
            maze_oe  <= 1'b0;
            maze_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt     <= ONE << win;
                        row     <= req_row[int'(win)*ADDR_W +: ADDR_W];
                        col     <= req_col[int'(win)*ADDR_W +: ADDR_W];
                        maze_we <= req_we[win];
                        maze_oe <= ~req_we[win];
                        rr_ptr  <= win;
                        cur     <= win;
                        busy    <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    gnt <= '0;
                    if (maze_we) begin
                        maze_we <= 1'b0;
                        maze_oe <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rd_data  <= maze_in;
                    rd_valid <= ONE << cur;
                    maze_oe  <= 1'b0;
                    state    <= RESP;
                end
                RESP: begin
                    rd_valid <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maze_port_arbiter.sv
// tb/tb_maze_port_arbiter.sv - directed self-checking bench for maze_port_arbiter
module tb_maze_port_arbiter;
    localparam int N_REQ  = 2;
    localparam int ADDR_W = 6;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [N_REQ-1:0]        req = '0;
    logic [N_REQ-1:0]        req_we = '0;
    logic [N_REQ*ADDR_W-1:0] req_row = '0;
    logic [N_REQ*ADDR_W-1:0] req_col = '0;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        rd_valid;
    logic                    rd_data;
    logic                    busy;
    logic [ADDR_W-1:0]       row;
    logic [ADDR_W-1:0]       col;
    logic                    maze_oe;
    logic                    maze_we;
    logic                    maze_in = 1'b0;

    int assertions = 0;
    int failures   = 0;
    int oe_count   = 0;
    int wr_count   = 0;

    logic mem [0:63][0:63];

    maze_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we),
        .req_row(req_row), .req_col(req_col), .gnt(gnt), .rd_valid(rd_valid),
        .rd_data(rd_data), .busy(busy), .row(row), .col(col),
        .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in)
    );

    always #5 clk = ~clk;

    // Memory model: registered read one cycle after address+oe, writes mark a path (0).
    always @(posedge clk) begin
        if (maze_oe) maze_in <= mem[row][col];
        if (maze_we) mem[row][col] <= 1'b0;
        if (maze_oe) oe_count <= oe_count + 1;
        if (maze_we) wr_count <= wr_count + 1;
    end

    always @(negedge clk) begin
        assertions++;
        if (!$onehot0(gnt) || !$onehot0(rd_valid) || (maze_oe && maze_we)) begin
            failures++;
            $display("FAIL invariant: gnt=%b rd_valid=%b oe=%b we=%b required onehot0/onehot0/not both",
                     gnt, rd_valid, maze_oe, maze_we);
        end
    end

    task automatic set_req(input int i, input logic we, input logic [ADDR_W-1:0] r,
                           input logic [ADDR_W-1:0] c);
        req_we[i] = we;
        req_row[i*ADDR_W +: ADDR_W] = r;
        req_col[i*ADDR_W +: ADDR_W] = c;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        assertions++;
        if ({gnt, rd_valid, rd_data, busy, row, col, maze_oe, maze_we} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%b busy=%b row=%0d col=%0d oe=%b we=%b required all 0",
                     gnt, rd_valid, rd_data, busy, row, col, maze_oe, maze_we);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        set_req(0, 1'b0, 6'd5, 6'd9);
        req = 2'b01;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b01 || row !== 6'd5 || col !== 6'd9 || maze_oe !== 1'b1 || maze_we !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL read_grant: got gnt=%b row=%0d col=%0d oe=%b we=%b busy=%b required 01/5/9/1/0/1",
                     gnt, row, col, maze_oe, maze_we, busy);
        end
        req = 2'b00;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b00 || maze_oe !== 1'b1 || rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL read_issue: got gnt=%b oe=%b rv=%b required 00/1/00", gnt, maze_oe, rd_valid);
        end
        @(negedge clk);
        assertions++;
        if (rd_valid !== 2'b01 || rd_data !== 1'b1 || maze_oe !== 1'b0) begin
            failures++;
            $display("FAIL read_resp: got rv=%b rd=%b oe=%b required 01/1/0", rd_valid, rd_data, maze_oe);
        end
        @(negedge clk);
        assertions++;
        if (rd_valid !== 2'b00 || busy !== 1'b0 || rd_data !== 1'b1 || row !== 6'd5) begin
            failures++;
            $display("FAIL read_done: got rv=%b busy=%b rd=%b row=%0d required 00/0/1/5", rd_valid, busy, rd_data, row);
        end
    endtask

    task automatic test_single_write;
        int w0;
        w0 = wr_count;
        set_req(1, 1'b1, 6'd63, 6'd0);
        req = 2'b10;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b10 || maze_we !== 1'b1 || maze_oe !== 1'b0 || row !== 6'd63 || col !== 6'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL write_grant: got gnt=%b we=%b oe=%b row=%0d col=%0d busy=%b required 10/1/0/63/0/1",
                     gnt, maze_we, maze_oe, row, col, busy);
        end
        req = 2'b00;
        @(negedge clk);
        assertions++;
        if (gnt !== 2'b00 || maze_we !== 1'b0 || busy !== 1'b0 || wr_count != w0 + 1 || mem[63][0] !== 1'b0) begin
            failures++;
            $display("FAIL write_done: got gnt=%b we=%b busy=%b writes=%0d mem=%b required 00/0/0/%0d/0",
                     gnt, maze_we, busy, wr_count - w0, mem[63][0], 1);
        end
    endtask

    task automatic test_contention;
        logic [N_REQ-1:0] exp_g;
        logic             exp_d;
        do_reset();
        set_req(0, 1'b0, 6'd5, 6'd9);
        set_req(1, 1'b0, 6'd2, 6'd3);
        req = 2'b11;
        for (int n = 0; n < 4; n++) begin
            exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
            exp_d = (n % 2 == 0) ? 1'b1 : 1'b0;
            for (int c = 0; c < 8 && gnt === 2'b00; c++) @(negedge clk);
            assertions++;
            if (gnt !== exp_g) begin
                failures++;
                $display("FAIL contention_gnt[%0d]: got %b required %b", n, gnt, exp_g);
            end
            @(negedge clk);
            @(negedge clk);
            assertions++;
            if (rd_valid !== exp_g || rd_data !== exp_d) begin
                failures++;
                $display("FAIL contention_rv[%0d]: got rv=%b rd=%b required %b/%b", n, rd_valid, rd_data, exp_g, exp_d);
            end
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_withdraw;
        int  oe0;
        int  wr0;
        logic saw_g1;
        saw_g1 = 1'b0;
        oe0 = oe_count;
        wr0 = wr_count;
        set_req(0, 1'b0, 6'd5, 6'd9);
        set_req(1, 1'b1, 6'd10, 6'd10);
        req = 2'b01;
        for (int c = 0; c < 4 && gnt === 2'b00; c++) @(negedge clk);
        assertions++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL withdraw_gnt0: got %b required 01", gnt);
        end
        req = 2'b00;
        @(negedge clk);
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        for (int c = 0; c < 6; c++) begin
            if (gnt[1]) saw_g1 = 1'b1;
            @(negedge clk);
        end
        assertions++;
        if (saw_g1 !== 1'b0 || oe_count - oe0 != 2 || wr_count != wr0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw: got gnt1_seen=%b oe_cycles=%0d writes=%0d busy=%b required 0/2/0/0",
                     saw_g1, oe_count - oe0, wr_count - wr0, busy);
        end
    endtask

    task automatic test_reset_mid_read;
        set_req(0, 1'b0, 6'd5, 6'd9);
        set_req(1, 1'b0, 6'd2, 6'd3);
        req = 2'b01;
        for (int c = 0; c < 4 && gnt === 2'b00; c++) @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        assertions++;
        if (maze_oe !== 1'b1 || busy !== 1'b1 || rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL midread_wait: got oe=%b busy=%b rv=%b required 1/1/00", maze_oe, busy, rd_valid);
        end
        rst = 1'b1;
        #1;
        assertions++;
        if ({gnt, rd_valid, rd_data, busy, row, col, maze_oe, maze_we} !== '0) begin
            failures++;
            $display("FAIL midread_reset: got gnt=%b rv=%b rd=%b busy=%b row=%0d col=%0d oe=%b we=%b required all 0",
                     gnt, rd_valid, rd_data, busy, row, col, maze_oe, maze_we);
        end
        @(negedge clk);
        assertions++;
        if (rd_valid !== 2'b00) begin
            failures++;
            $display("FAIL midread_no_rv: got %b required 00", rd_valid);
        end
        rst = 1'b0;
        req = 2'b11;
        for (int c = 0; c < 4 && gnt === 2'b00; c++) @(negedge clk);
        assertions++;
        if (gnt !== 2'b01) begin
            failures++;
            $display("FAIL midread_rr_reset: got %b required 01", gnt);
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        assertions++;
        if (rd_valid !== 2'b01 || rd_data !== 1'b1) begin
            failures++;
            $display("FAIL midread_after: got rv=%b rd=%b required 01/1", rd_valid, rd_data);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++)
                mem[r][c] = 1'b1;
        mem[2][3] = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_contention();
        test_withdraw();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule
